// File: rtl/start_cloud_hps_system_sw_debounce.sv
// Slide-switch conditioner: 2-flop synchronizer plus per-bit debounce.
// Registered clean state and one-cycle rise/fall/changed pulses.
module start_cloud_hps_system_sw_debounce #(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16,
  parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_async,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             chg_q;
  logic             chg_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per-bit debounce: count consecutive disagreeing edges, then commit.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    chg_d = |(rise_d | fall_d);
  end

  // Synchronizer, counters, clean state and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= INIT_VALUE;
      sync2_q <= INIT_VALUE;
      clean_q <= INIT_VALUE;
      rise_q  <= '0;
      fall_q  <= '0;
      chg_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sw_async;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chg_q   <= chg_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign changed  = chg_q;

endmodule
